// File: rtl/spi_cmd_pkg.sv
// ============================================================================
// Module      : spi_cmd_pkg
// Description : Shared state encoding, command-word field layout and the
//               active-low chip-select helper for the SPI command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_cmd_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_WRITE = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int SS_W     = 16;
    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int CMD_W    = 32;
    localparam int ENTRY_W  = ADDR_W + DATA_W;
    localparam int CHIP_W   = 4;

    // Command word: {ss_n[31:16], addr[15:8], data[7:0]}
    localparam int SS_LSB   = ENTRY_W;
    localparam int ADDR_LSB = DATA_W;
    localparam int DATA_LSB = 0;

    // Chip selects are active low: the selected chip's bit is the only zero.
    function automatic logic [SS_W-1:0] cs_onehot_n(input logic [CHIP_W-1:0] chip);
        return ~(SS_W'(1) << chip);
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_cmd_table.sv
// ============================================================================
// Module      : spi_cmd_table
// Description : DEPTH x 16-bit {addr, data} register table; synchronous
//               write, combinational read, asynchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_cmd_table
    import spi_cmd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDXW  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [IDXW-1:0]    wr_idx,
    input  logic [ENTRY_W-1:0] wr_entry,
    input  logic [IDXW-1:0]    rd_idx,
    output logic [ENTRY_W-1:0] rd_entry
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[wr_idx] <= wr_entry;
        end
    end

    assign rd_entry = r_mem[rd_idx];

endmodule

`default_nettype wire

// File: rtl/spi_cmd_sequencer.sv
// ============================================================================
// Module      : spi_cmd_sequencer
// Description : Replays the first N table entries as 32-bit SPI command words
//               into the SPI master FIFO, honouring fifo_full and an
//               inter-word gap. SPI_CMD_MULTICAST_EN adds a cs_mask port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_cmd_sequencer
    import spi_cmd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int GAP   = 4,
    parameter int IDXW  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [IDXW-1:0]   prog_idx,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              start,
    input  logic [CHIP_W-1:0] chip,
    input  logic [IDXW:0]     count,
`ifdef SPI_CMD_MULTICAST_EN
    input  logic [SS_W-1:0]   cs_mask,
`endif
    input  logic              abort,
    input  logic              fifo_full,
    output logic              wr_en,
    output logic [CMD_W-1:0]  wr_data,
    output logic              busy,
    output logic              done
);

    localparam int               GAP_W     = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);
    localparam logic [IDXW:0]    DEPTH_CNT = (IDXW+1)'(DEPTH);
    localparam logic [IDXW:0]    CNT_ONE   = (IDXW+1)'(1);
    localparam logic [IDXW-1:0]  IDX_ONE   = IDXW'(1);

    state_t             r_state;
    state_t             w_state_n;
    logic [IDXW-1:0]    r_idx;
    logic [IDXW:0]      r_last;
    logic [SS_W-1:0]    r_ss;
    logic [GAP_W-1:0]   r_gap;

    logic [ENTRY_W-1:0] w_entry;
    logic [IDXW:0]      w_cnt_clamp;
    logic [SS_W-1:0]    w_ss_start;
    logic               w_prog_we;
    logic               w_accept;
    logic               w_idx_inc;
    logic               w_gap_load;
    logic               w_gap_dec;
    logic               w_wr_en_n;
    logic               w_done_n;
    logic               w_busy_n;

    assign w_prog_we   = prog_we && !busy;
    assign w_cnt_clamp = (count > DEPTH_CNT) ? DEPTH_CNT : count;

`ifdef SPI_CMD_MULTICAST_EN
    assign w_ss_start = (cs_mask != '0) ? ~cs_mask : cs_onehot_n(chip);
`else
    assign w_ss_start = cs_onehot_n(chip);
`endif

    spi_cmd_table #(
        .DEPTH (DEPTH),
        .IDXW  (IDXW)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .we       (w_prog_we),
        .wr_idx   (prog_idx),
        .wr_entry ({prog_addr, prog_data}),
        .rd_idx   (r_idx),
        .rd_entry (w_entry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_accept   = 1'b0;
        w_idx_inc  = 1'b0;
        w_gap_load = 1'b0;
        w_gap_dec  = 1'b0;
        w_wr_en_n  = 1'b0;
        w_done_n   = 1'b0;
        w_busy_n   = busy;

        case (r_state)
            S_IDLE: begin
                if (start && !abort && (count != '0)) begin
                    w_state_n = S_CHECK;
                    w_accept  = 1'b1;
                    w_busy_n  = 1'b1;
                end
            end
            S_CHECK: begin
                if (!fifo_full) begin
                    w_state_n = S_WRITE;
                end
            end
            S_WRITE: begin
                w_wr_en_n = 1'b1;
                if ({1'b0, r_idx} == r_last) begin
                    w_state_n = S_DONE;
                end else begin
                    w_idx_inc = 1'b1;
                    if (GAP == 0) begin
                        w_state_n = S_CHECK;
                    end else begin
                        w_state_n  = S_GAP;
                        w_gap_load = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (r_gap == '0) begin
                    w_state_n = S_CHECK;
                end else begin
                    w_gap_dec = 1'b1;
                end
            end
            S_DONE: begin
                w_done_n  = 1'b1;
                w_busy_n  = 1'b0;
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
                w_busy_n  = 1'b0;
            end
        endcase

        // Abort overrides everything outside idle; a word already on wr_en stays valid.
        if (abort && (r_state != S_IDLE)) begin
            w_state_n  = S_IDLE;
            w_busy_n   = 1'b0;
            w_wr_en_n  = 1'b0;
            w_done_n   = 1'b0;
            w_idx_inc  = 1'b0;
            w_gap_load = 1'b0;
            w_gap_dec  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_last  <= '0;
            r_ss    <= '0;
            r_gap   <= '0;
            wr_en   <= 1'b0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            wr_en <= w_wr_en_n;
            done  <= w_done_n;
            busy  <= w_busy_n;

            if (w_accept) begin
                r_idx  <= '0;
                r_last <= w_cnt_clamp - CNT_ONE;
                r_ss   <= w_ss_start;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + IDX_ONE;
            end

            if (w_gap_load) begin
                r_gap <= GAP_LOAD;
            end else if (w_gap_dec) begin
                r_gap <= r_gap - GAP_ONE;
            end

            if (w_wr_en_n) begin
                wr_data <= {r_ss, w_entry};
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_sequencer.sv
// ============================================================================
// Module      : tb_spi_cmd_sequencer
// Description : Self-checking bench for spi_cmd_sequencer (DEPTH=8, GAP=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_cmd_sequencer;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } wr_rec_t;

    typedef struct {
        logic [3:0]  chip;
        logic [3:0]  count;
        int          exp_n;
        logic [31:0] exp_first;
        bit          prog_busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [2:0]  prog_idx;
    logic [7:0]  prog_addr;
    logic [7:0]  prog_data;
    logic        start;
    logic [3:0]  chip;
    logic [3:0]  count;
    logic        abort;
    logic        fifo_full;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;

    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          wr_cnt   = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [31:0] exp_q [$];
    wr_rec_t     wr_log [$];
    logic [15:0] model_tab [8];
    vec_t        vecs [5];

    always #5 clk = ~clk;

    spi_cmd_sequencer #(
        .DEPTH (8),
        .GAP   (4),
        .IDXW  (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_idx  (prog_idx),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .chip      (chip),
        .count     (count),
        .abort     (abort),
        .fifo_full (fifo_full),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cmd_word(input logic [3:0] ch, input logic [15:0] entry);
        return {~(16'h0001 << ch), entry};
    endfunction

    // Output monitor and scoreboard consumer, sampled on the falling edge.
    initial begin
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (wr_en) begin
                    wr_cnt++;
                    wr_log.push_back('{data: wr_data, cyc: cyc});
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: actual=%h expected=none", wr_data);
                    end else begin
                        exp = exp_q.pop_front();
                        check("wr_data", wr_data, exp);
                    end
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic prog(input int i, input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        prog_we   = 1'b1;
        prog_idx  = 3'(i);
        prog_addr = a;
        prog_data = d;
        @(posedge clk); #1;
        prog_we   = 1'b0;
        model_tab[i] = {a, d};
    endtask

    task automatic start_pulse(input logic [3:0] ch, input logic [3:0] cnt, output int c0);
        @(posedge clk); #1;
        chip  = ch;
        count = cnt;
        start = 1'b1;
        c0    = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int k = 0; k < budget && done_cnt == d0; k++) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic run_seq(input logic [3:0] ch, input logic [3:0] cnt, input int exp_n,
                           input logic [31:0] exp_first, input bit prog_busy);
        int c0;
        int d0;
        int bad;
        wr_log.delete();
        for (int i = 0; i < exp_n; i++) exp_q.push_back(cmd_word(ch, model_tab[i]));
        d0 = done_cnt;
        start_pulse(ch, cnt, c0);
        if (prog_busy) begin
            prog_we   = 1'b1;
            prog_idx  = 3'd1;
            prog_addr = 8'hEE;
            prog_data = 8'hEE;
            repeat (3) @(posedge clk);
            #1 prog_we = 1'b0;
        end
        wait_done(d0, 200);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("busy_after_done", 32'(busy), 32'd0);
        check("write_count", 32'(wr_log.size()), 32'(exp_n));
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        if (wr_log.size() > 0) begin
            check("first_word", wr_log[0].data, exp_first);
            check("first_latency", 32'(wr_log[0].cyc - c0), 32'd4);
            check("done_after_last", 32'(done_cyc - wr_log[wr_log.size()-1].cyc), 32'd1);
            bad = 0;
            for (int i = 1; i < wr_log.size(); i++) begin
                if (wr_log[i].cyc - wr_log[i-1].cyc != 6) bad++;
            end
            check("word_spacing", 32'(bad), 32'd0);
        end
        exp_q.delete();
    endtask

    initial begin
        int  c0;
        int  cf;
        int  d0;
        int  wr0;
        bit  bhigh;

        rst = 1'b1; prog_we = 1'b0; prog_idx = '0; prog_addr = '0; prog_data = '0;
        start = 1'b0; chip = '0; count = '0; abort = 1'b0; fifo_full = 1'b0;
        for (int i = 0; i < 8; i++) model_tab[i] = '0;

        vecs[0] = '{4'd3,  4'd3,  3, 32'hFFF710A5, 1'b0};
        vecs[1] = '{4'd0,  4'd1,  1, 32'hFFFE10A5, 1'b0};
        vecs[2] = '{4'd15, 4'd15, 8, 32'h7FFF10A5, 1'b0};
        vecs[3] = '{4'd8,  4'd8,  8, 32'hFEFF10A5, 1'b1};
        vecs[4] = '{4'd5,  4'd2,  2, 32'hFFDF10A5, 1'b0};

        repeat (3) @(negedge clk);
        #1;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        prog(0, 8'h10, 8'hA5);
        prog(1, 8'h11, 8'h5A);
        prog(2, 8'h12, 8'hFF);
        for (int i = 3; i < 8; i++) prog(i, 8'(8'h10 + i), 8'(8'h30 + i));

        for (int v = 0; v < 5; v++) begin
            run_seq(vecs[v].chip, vecs[v].count, vecs[v].exp_n, vecs[v].exp_first, vecs[v].prog_busy);
        end

        // count = 0 is ignored
        wr0 = wr_cnt; d0 = done_cnt; bhigh = 1'b0;
        start_pulse(4'd3, 4'd0, c0);
        repeat (10) begin @(negedge clk); #1; if (busy) bhigh = 1'b1; end
        check("cnt0_busy", 32'(bhigh), 32'd0);
        check("cnt0_writes", 32'(wr_cnt - wr0), 32'd0);
        check("cnt0_done", 32'(done_cnt - d0), 32'd0);

        // start and abort together while idle: nothing starts
        wr0 = wr_cnt; bhigh = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; chip = 4'd3; count = 4'd3;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        repeat (10) begin @(negedge clk); #1; if (busy) bhigh = 1'b1; end
        check("start_abort_busy", 32'(bhigh), 32'd0);
        check("start_abort_writes", 32'(wr_cnt - wr0), 32'd0);

        // fifo_full held for 20 cycles after start
        wr_log.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(cmd_word(4'd3, model_tab[i]));
        fifo_full = 1'b1; wr0 = wr_cnt; d0 = done_cnt;
        start_pulse(4'd3, 4'd3, c0);
        repeat (19) @(posedge clk);
        #1;
        cf = cyc;
        fifo_full = 1'b0;
        check("no_write_while_full", 32'(wr_cnt - wr0), 32'd0);
        wait_done(d0, 200);
        check("full_done", 32'(done_cnt - d0), 32'd1);
        check("full_write_count", 32'(wr_log.size()), 32'd3);
        if (wr_log.size() > 0) check("full_release_latency", 32'(wr_log[0].cyc - cf), 32'd3);
        check("full_sb_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // abort after the second write of a 5-entry sequence
        wr_log.delete();
        for (int i = 0; i < 2; i++) exp_q.push_back(cmd_word(4'd2, model_tab[i]));
        wr0 = wr_cnt; d0 = done_cnt;
        start_pulse(4'd2, 4'd5, c0);
        for (int k = 0; k < 100 && (wr_cnt - wr0) < 2; k++) begin @(negedge clk); #1; end
        check("abort_pre_writes", 32'(wr_cnt - wr0), 32'd2);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        repeat (30) @(negedge clk);
        #1;
        check("abort_no_more_writes", 32'(wr_cnt - wr0), 32'd2);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        exp_q.delete();
        run_seq(4'd2, 4'd5, 5, 32'hFFFB10A5, 1'b0);

        // asynchronous reset in the middle of a gap
        wr_log.delete();
        exp_q.push_back(cmd_word(4'd3, model_tab[0]));
        wr0 = wr_cnt;
        start_pulse(4'd3, 4'd3, c0);
        for (int k = 0; k < 100 && (wr_cnt - wr0) < 1; k++) begin @(negedge clk); #1; end
        @(posedge clk); #3;
        check("pre_reset_data", wr_data, 32'hFFF710A5);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_wr_en", 32'(wr_en), 32'd0);
        check("async_rst_wr_data", wr_data, 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        exp_q.delete();
        for (int i = 0; i < 8; i++) model_tab[i] = '0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        run_seq(4'd0, 4'd1, 1, 32'hFFFE0000, 1'b0);
        run_seq(4'd9, 4'd8, 8, 32'hFDFF0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
